// File: rtl/sap1_pkg.sv
// sap1_pkg: opcodes, control-bit indices, control words and one-hot T-states for the SAP-1 sequencer
package sap1_pkg;
  localparam logic [3:0] OP_LDA = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_OUT = 4'hE, OP_HLT = 4'hF;
  localparam int CP_B = 11, EP_B = 10, NLM_B = 9, NCE_B = 8, NLI_B = 7, NEI_B = 6;
  localparam int NLA_B = 5, EA_B = 4, SU_B = 3, EU_B = 2, NLB_B = 1, NLO_B = 0;
  localparam logic [11:0] CON_IDLE   = 12'h3E3;
  localparam logic [11:0] CON_T1     = 12'h5E3;
  localparam logic [11:0] CON_T2     = 12'hBE3;
  localparam logic [11:0] CON_T3     = 12'h263;
  localparam logic [11:0] CON_MEM_T4 = 12'h1A3;
  localparam logic [11:0] CON_OUT_T4 = 12'h3F2;
  localparam logic [11:0] CON_LDA_T5 = 12'h2C3;
  localparam logic [11:0] CON_ALU_T5 = 12'h2E1;
  localparam logic [11:0] CON_ADD_T6 = 12'h3C7;
  localparam logic [11:0] CON_SUB_T6 = 12'h3CF;
  typedef enum logic [5:0] {
    T_OFF = 6'b000000,
    T1    = 6'b000001,
    T2    = 6'b000010,
    T3    = 6'b000100,
    T4    = 6'b001000,
    T5    = 6'b010000,
    T6    = 6'b100000
  } t_state_e;
endpackage

// File: rtl/sap1_control_sequencer_if.sv
// sap1_control_sequencer_if: sequencer bus; master = sequencer (opcode/run/step in, t_state/con/hlt out), slave = CPU side
interface sap1_control_sequencer_if #(parameter int NUM_T = 6);
  logic [3:0] opcode;
  logic run;
  logic step;
  logic [NUM_T-1:0] t_state;
  logic [11:0] con;
  logic hlt;
  modport master(input opcode, run, step, output t_state, con, hlt);
  modport slave(output opcode, run, step, input t_state, con, hlt);
endinterface

// File: rtl/sap1_t_state_gen.sv
// sap1_t_state_gen: one-hot T-state ring (falling edge); clr->T1, freeze->all zero, restart->T1, else rotate on adv
module sap1_t_state_gen
  import sap1_pkg::*;
(
  input  logic     clk,
  input  logic     clr,
  input  logic     adv,
  input  logic     restart,
  input  logic     freeze,
  output t_state_e t_state
);
  t_state_e nxt;
  always_ff @(negedge clk) t_state <= clr ? T1 : nxt;
  always_comb nxt = freeze ? T_OFF : !adv ? t_state : restart ? T1 : t_state_e'({t_state[4:0], t_state[5]});
endmodule

// File: rtl/sap1_control_sequencer.sv
// sap1_control_sequencer: SAP-1 controller-sequencer; clk/clr (falling edge, sync) plus bus with opcode/run/step in and t_state/con/hlt out
module sap1_control_sequencer
  import sap1_pkg::*;
#(
  parameter bit VARIABLE_CYCLE = 1'b1,
  parameter int NUM_T = 6
) (
  input logic clk,
  input logic clr,
  sap1_control_sequencer_if.master bus
);
  t_state_e ts;
  logic [NUM_T-1:0] t_cur;
  logic [3:0] op;
  logic step_q, halted, adv, halt_set, known, last, restart;
  logic [11:0] con;
  assign t_cur = ts;
  assign op = bus.opcode;
  always_ff @(negedge clk) begin
    step_q <= clr ? 1'b0 : bus.step;
    halted <= !clr && (halted || halt_set);
  end
  always_comb begin
    adv = bus.run | (bus.step & ~step_q);
    halt_set = adv & t_cur[3] & (op == OP_HLT);
    known = op inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT};
    last = t_cur[5] | (t_cur[4] & (op == OP_LDA)) | (t_cur[3] & (op == OP_OUT || op == OP_HLT)) | (t_cur[2] & !known);
    restart = VARIABLE_CYCLE && last;
    con = t_cur[0] ? CON_T1 :
          t_cur[1] ? CON_T2 :
          t_cur[2] ? CON_T3 :
          t_cur[3] ? (op == OP_OUT ? CON_OUT_T4 : op inside {OP_LDA, OP_ADD, OP_SUB} ? CON_MEM_T4 : CON_IDLE) :
          t_cur[4] ? (op == OP_LDA ? CON_LDA_T5 : (op == OP_ADD || op == OP_SUB) ? CON_ALU_T5 : CON_IDLE) :
          t_cur[5] ? (op == OP_ADD ? CON_ADD_T6 : op == OP_SUB ? CON_SUB_T6 : CON_IDLE) : CON_IDLE;
  end
  sap1_t_state_gen u_tgen (
    .clk(clk),
    .clr(clr),
    .adv(adv),
    .restart(restart),
    .freeze(halted | halt_set),
    .t_state(ts)
  );
  assign bus.t_state = t_cur;
  assign bus.con = con;
  assign bus.hlt = halted;
endmodule

// File: doc/sap1_control_sequencer.md
# sap1_control_sequencer

SAP-1 controller-sequencer. It generates the one-hot T-state sequence and decodes it with the instruction-register opcode into the 12-bit control word that drives PC, MAR, RAM, IR, accumulator, adder/subtractor, B and output registers. Machine cycles are variable length: each instruction returns to T1 as soon as its last active state completes. The block also provides run/single-step control and HLT latching, and replaces the fixed 6-state ring counter as the CPU's timing source.

## Interface

Parameters:
- VARIABLE_CYCLE, default 1: 1 enables early return to T1 per opcode; 0 always runs all six states, T1..T6.
- NUM_T, default 6: number of T-states. Fixed at 6; the parameter exists only for the width of t_state.

Ports:
- clk, in, 1: system clock. All registers update on the falling edge of clk.
- clr, in, 1: synchronous, active-high reset, sampled on the same falling edge.
- opcode, in, 4: IR[7:4]. Valid from the end of T3 onward.
- run, in, 1: 1 = free run; 0 = single-step mode.
- step, in, 1: single-step request, synchronous to clk. Level input; only its rising edge is used.
- t_state, out, 6: one-hot T-state. Bit0 = T1 … bit5 = T6. All zero while halted.
- con, out, 12: control word {Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo}, bit11..bit0.
- hlt, out, 1: halted flag. When high, the external clock gate is stopped.

## Operation

- Opcodes: LDA=4'h0, ADD=4'h1, SUB=4'h2, OUT=4'hE, HLT=4'hF. Every other opcode is a NOP.
- con is a pure decode of the registered state and opcode.
- Idle word CON_IDLE = 12'h3E3: all active-low signals high, all active-high signals low.
- Fetch cycle, same for every opcode:
  - T1 = 12'h5E3 (Ep, nLm)
  - T2 = 12'hBE3 (Cp)
  - T3 = 12'h263 (nCE, nLi)
- Execute states:
  - LDA: T4 = 1A3 (nLm, nEi); T5 = 2C3 (nCE, nLa); T6 = idle.
  - ADD: T4 = 1A3; T5 = 2E1 (nCE, nLb); T6 = 3C7 (nLa, Eu).
  - SUB: T4 = 1A3; T5 = 2E1; T6 = 3CF (nLa, Su, Eu).
  - OUT: T4 = 3F2 (Ea, nLo); T5 and T6 = idle.
  - HLT and NOP: T4..T6 = idle.
- Last active state, used when VARIABLE_CYCLE=1:
  - LDA: T5
  - ADD, SUB: T6
  - OUT: T4
  - NOP: T3
  - HLT: T4
- After the last active state the next state is T1. Otherwise the state rotates left by one.
- Halt: on the falling edge that ends T4 with opcode=HLT, the halted register sets.
  - While halted: t_state = 0, con = CON_IDLE, hlt = 1.
  - The block holds this until clr. run and step are ignored.
- Advance enable adv = run | step_rise, where step_rise = step & ~step_q.
  - step_q is a registered copy of step.
  - When adv=0, state holds and con holds its decode.
- clr overrides everything: t_state = 000001, halted = 0, step_q = 0.

## Timing

- Reset values on the first falling edge with clr=1: t_state = 6'b000001, con = 12'h5E3, hlt = 0.
- Transition latency: one falling edge per T-state when adv=1.
- con follows t_state combinationally, so it is stable at every rising edge, where the datapath loads.
- opcode is read only during T3..T6. Changes on opcode during T1..T2 have no effect.
- opcode is sampled at the end of T3 only for the NOP early return. In T4..T6 it is decoded live.
- In step mode:
  - Each low-to-high transition of step advances exactly one state.
  - A held-high step advances only once.
  - step that is already high when run drops produces no extra advance.
- clr asserted mid-instruction, in any state or while halted: the next state is T1 and hlt drops on the same edge.
- clr has priority over a simultaneous HLT latch and over step.

## Structure

- Package sap1_pkg holds:
  - opcode localparams
  - control-bit index localparams (CP_B = 11 … NLO_B = 0)
  - CON_IDLE and the per-state control words
  - T1..T6 one-hot constants
- Sub-module sap1_t_state_gen: the rotating one-hot register.
  - Inputs: clk, clr, adv, restart (forces T1), freeze (forces zero).
  - Output: t_state.
- The top level contains the step edge detector, the halt register, the early-return decode and the control-word decode.

## Test plan

- Reset: clr=1 for 2 edges, then 0, with run=1 and opcode=LDA. Expect t_state sequence 01,02,04,08,10,01 and con 5E3, BE3, 263, 1A3, 2C3, 5E3.
- Opcode SUB with VARIABLE_CYCLE=1. Expect all six states, with T6 con = 3CF. With opcode=OUT, expect T4 con = 3F2 and the next state is T1. With opcode=4'h5, expect the return to T1 after T3.
- VARIABLE_CYCLE=0 with opcode=OUT. Expect T5 and T6 present, both con = 3E3.
- Opcode HLT. Expect hlt=1 after the T4 edge, t_state = 0 and con = 3E3 for 20 cycles. Then clr=1 gives t_state = 01, hlt = 0.
- run=0, step held high for 5 cycles, then three clean pulses. Expect exactly four advances total.
- clr pulsed during T5 of ADD. Expect t_state = 01 on that edge and no nLa/Eu word emitted.
